addr_decoder_arbiter: RTL and testbench

ADDR_DECODER_ARBITER -- requirements
Module: addr_decoder_arbiter

---
 rtl/addr_decoder_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_addr_decoder_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_decoder_arbiter.sv
// Round-robin arbiter that forwards one of four requesters' ops to a single decoder port.
// Tracks per-requester outstanding ops and returns decoder completions as one-hot pulses.
module addr_decoder_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_enable,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [3:0]  req_wr_rd_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wr_data,
    input  logic [23:0] req_op_id,
    output logic [3:0]  req_err,
    output logic [3:0]  rsp_valid,
    output logic [5:0]  rsp_op_id,
    output logic [7:0]  rsp_rd_data,
    output logic        enable_in,
    output logic        wr_rd_op,
    output logic        valid_in,
    output logic [7:0]  addr_in,
    output logic [7:0]  op_in_id,
    output logic [7:0]  wr_data_in,
    input  logic        ready_out,
    input  logic [7:0]  rd_data_out,
    input  logic [7:0]  done_op_id
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    localparam logic [3:0] MaxCnt = 4'(MAX_OUTSTANDING);

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  cnt_q [4];
    logic [3:0]  cnt_d [4];
    logic        enable_in_q, enable_in_d;
    logic        wr_rd_op_q, wr_rd_op_d;
    logic [7:0]  addr_in_q, addr_in_d;
    logic [7:0]  op_in_id_q, op_in_id_d;
    logic [7:0]  wr_data_in_q, wr_data_in_d;
    logic [3:0]  rsp_valid_q, rsp_valid_d;
    logic [5:0]  rsp_op_id_q, rsp_op_id_d;
    logic [7:0]  rsp_rd_data_q, rsp_rd_data_d;

    logic [7:0]  addr_arr [4];
    logic [7:0]  data_arr [4];
    logic [5:0]  id_arr [4];
    logic [3:0]  eligible;
    logic [3:0]  inc_vec, dec_vec;
    logic [1:0]  cand;
    logic [1:0]  win_idx;
    logic        win_found;
    logic        grant_ok;
    logic        id_bad;
    logic        accept;
    logic        done_hit;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            addr_arr[i] = req_addr[8*i +: 8];
            data_arr[i] = req_wr_data[8*i +: 8];
            id_arr[i]   = req_op_id[6*i +: 6];
            eligible[i] = req_valid[i] && (cnt_q[i] < MaxCnt);
        end
    end

    // First eligible requester scanning upward from rr_ptr, wrapping at 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant_ok = (state_q == StIdle) && cfg_enable && win_found;
    assign id_bad   = (id_arr[win_idx] == 6'd0);
    assign accept   = (state_q == StIssue) && ready_out;
    assign done_hit = (done_op_id != 8'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            cnt_q         <= '{default: '0};
            enable_in_q   <= 1'b0;
            wr_rd_op_q    <= 1'b0;
            addr_in_q     <= '0;
            op_in_id_q    <= '0;
            wr_data_in_q  <= '0;
            rsp_valid_q   <= '0;
            rsp_op_id_q   <= '0;
            rsp_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            enable_in_q   <= enable_in_d;
            wr_rd_op_q    <= wr_rd_op_d;
            addr_in_q     <= addr_in_d;
            op_in_id_q    <= op_in_id_d;
            wr_data_in_q  <= wr_data_in_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_op_id_q   <= rsp_op_id_d;
            rsp_rd_data_q <= rsp_rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_ok && !id_bad) state_d = StIssue;
            StIssue: if (ready_out)           state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        enable_in_d  = cfg_enable;
        wr_rd_op_d   = wr_rd_op_q;
        addr_in_d    = addr_in_q;
        op_in_id_d   = op_in_id_q;
        wr_data_in_d = wr_data_in_q;
        if (accept) begin
            rr_ptr_d = grant_q + 2'd1;
        end else if (grant_ok) begin
            if (id_bad) begin
                rr_ptr_d = win_idx + 2'd1;
            end else begin
                grant_d      = win_idx;
                wr_rd_op_d   = req_wr_rd_op[win_idx];
                addr_in_d    = addr_arr[win_idx];
                wr_data_in_d = data_arr[win_idx];
                op_in_id_d   = {win_idx, id_arr[win_idx]};
            end
        end
    end

    // Same-edge accept and completion for one requester cancel out.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inc_vec[i] = accept && (grant_q == 2'(i));
            dec_vec[i] = done_hit && (done_op_id[7:6] == 2'(i));
            cnt_d[i]   = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i] && (cnt_q[i] < MaxCnt)) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end
    end

    always_comb begin
        rsp_valid_d   = '0;
        rsp_op_id_d   = rsp_op_id_q;
        rsp_rd_data_d = rsp_rd_data_q;
        if (done_hit) begin
            rsp_valid_d[done_op_id[7:6]] = 1'b1;
            rsp_op_id_d                  = done_op_id[5:0];
            rsp_rd_data_d                = rd_data_out;
        end
    end

    always_comb begin
        req_ready = '0;
        req_err   = '0;
        if (!reset && grant_ok) begin
            req_ready[win_idx] = 1'b1;
            req_err[win_idx]   = id_bad;
        end
    end

    assign valid_in    = (state_q == StIssue);
    assign enable_in   = enable_in_q;
    assign wr_rd_op    = wr_rd_op_q;
    assign addr_in     = addr_in_q;
    assign op_in_id    = op_in_id_q;
    assign wr_data_in  = wr_data_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_op_id   = rsp_op_id_q;
    assign rsp_rd_data = rsp_rd_data_q;

endmodule

// File: tb/tb_addr_decoder_arbiter.sv
// Bench for addr_decoder_arbiter: arbitration vectors, directed corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_addr_decoder_arbiter;

    localparam int MAX = 4;

    logic        clock;
    logic        reset;
    logic        cfg_enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_wr_rd_op;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic [23:0] req_op_id;
    logic [3:0]  req_err;
    logic [3:0]  rsp_valid;
    logic [5:0]  rsp_op_id;
    logic [7:0]  rsp_rd_data;
    logic        enable_in;
    logic        wr_rd_op;
    logic        valid_in;
    logic [7:0]  addr_in;
    logic [7:0]  op_in_id;
    logic [7:0]  wr_data_in;
    logic        ready_out;
    logic [7:0]  rd_data_out;
    logic [7:0]  done_op_id;

    addr_decoder_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_enable   (cfg_enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr_rd_op (req_wr_rd_op),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .req_op_id    (req_op_id),
        .req_err      (req_err),
        .rsp_valid    (rsp_valid),
        .rsp_op_id    (rsp_op_id),
        .rsp_rd_data  (rsp_rd_data),
        .enable_in    (enable_in),
        .wr_rd_op     (wr_rd_op),
        .valid_in     (valid_in),
        .addr_in      (addr_in),
        .op_in_id     (op_in_id),
        .wr_data_in   (wr_data_in),
        .ready_out    (ready_out),
        .rd_data_out  (rd_data_out),
        .done_op_id   (done_op_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_errors;
    int n_checks;
    int cyc;

    // Reference model state.
    int         m_issue, m_g, m_rr;
    int         m_out [4];
    logic       m_en, m_wr;
    logic [7:0] m_addr, m_wd, m_id;
    logic [3:0] m_rsp_v;
    logic [5:0] m_rsp_id;
    logic [7:0] m_rsp_d;

    // Values observed at the last sampling point.
    logic [3:0] obs_ready, obs_err, obs_rsp_v;
    logic       obs_vin;
    logic [7:0] obs_addr, obs_wd, obs_id, obs_rsp_d;
    logic [5:0] obs_rsp_id;

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic [23:0] ids;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_err;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_issue = 0; m_g = 0; m_rr = 0;
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_en = 1'b0; m_wr = 1'b0; m_addr = '0; m_wd = '0; m_id = '0;
        m_rsp_v = '0; m_rsp_id = '0; m_rsp_d = '0;
    endtask

    task automatic zero_inputs();
        cfg_enable = 1'b0; req_valid = '0; req_wr_rd_op = '0; req_addr = '0;
        req_wr_data = '0; req_op_id = '0; ready_out = 1'b0; rd_data_out = '0;
        done_op_id = '0;
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 of the first post-reset cycle.
    task automatic do_reset();
        reset = 1'b1;
        zero_inputs();
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_req_err", 32'(req_err), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_op_id", 32'(rsp_op_id), 0);
        check("rst_rsp_rd_data", 32'(rsp_rd_data), 0);
        check("rst_enable_in", 32'(enable_in), 0);
        check("rst_valid_in", 32'(valid_in), 0);
        check("rst_wr_rd_op", 32'(wr_rd_op), 0);
        check("rst_addr_in", 32'(addr_in), 0);
        check("rst_op_in_id", 32'(op_in_id), 0);
        check("rst_wr_data_in", 32'(wr_data_in), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, step to posedge+1.
    task automatic cycle();
        int         w, i, dr;
        logic [3:0] e_rdy, e_err;
        logic [5:0] wid;
        logic       done, acc;
        @(negedge clock);
        w = -1;
        if (m_issue == 0 && cfg_enable) begin
            for (int k = 0; k < 4; k++) begin
                i = (m_rr + k) % 4;
                if (w < 0 && req_valid[i] && m_out[i] < MAX) w = i;
            end
        end
        e_rdy = '0; e_err = '0; wid = '0;
        if (w >= 0) begin
            wid      = req_op_id[6*w +: 6];
            e_rdy[w] = 1'b1;
            if (wid == 6'd0) e_err[w] = 1'b1;
        end
        obs_ready = req_ready; obs_err = req_err; obs_vin = valid_in;
        obs_addr = addr_in; obs_wd = wr_data_in; obs_id = op_in_id;
        obs_rsp_v = rsp_valid; obs_rsp_id = rsp_op_id; obs_rsp_d = rsp_rd_data;

        check("req_ready", 32'(req_ready), 32'(e_rdy));
        check("req_err", 32'(req_err), 32'(e_err));
        check("valid_in", 32'(valid_in), 32'(m_issue != 0));
        check("enable_in", 32'(enable_in), 32'(m_en));
        if (m_issue != 0) begin
            check("addr_in", 32'(addr_in), 32'(m_addr));
            check("wr_data_in", 32'(wr_data_in), 32'(m_wd));
            check("op_in_id", 32'(op_in_id), 32'(m_id));
            check("wr_rd_op", 32'(wr_rd_op), 32'(m_wr));
        end
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        if (m_rsp_v != 0) begin
            check("rsp_op_id", 32'(rsp_op_id), 32'(m_rsp_id));
            check("rsp_rd_data", 32'(rsp_rd_data), 32'(m_rsp_d));
        end

        done = (done_op_id != 8'd0);
        dr   = int'(done_op_id[7:6]);
        acc  = (m_issue != 0) && ready_out;
        if (!(acc && done && dr == m_g)) begin
            if (acc && m_out[m_g] < MAX) m_out[m_g]++;
            if (done && m_out[dr] > 0) m_out[dr]--;
        end
        m_rsp_v = done ? (4'b0001 << dr) : 4'b0000;
        if (done) begin
            m_rsp_id = done_op_id[5:0];
            m_rsp_d  = rd_data_out;
        end
        m_en = cfg_enable;
        if (acc) begin
            m_issue = 0;
            m_rr    = (m_g + 1) % 4;
        end else if (w >= 0) begin
            if (wid == 6'd0) begin
                m_rr = (w + 1) % 4;
            end else begin
                m_issue = 1;
                m_g     = w;
                m_wr    = req_wr_rd_op[w];
                m_addr  = req_addr[8*w +: 8];
                m_wd    = req_wr_data[8*w +: 8];
                m_id    = {2'(w), wid};
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    int g_ids [$];
    int g_cyc [$];
    int n_gr;
    int lane;

    initial begin
        n_errors = 0; n_checks = 0; cyc = 0;
        reset = 1'b1;
        zero_inputs();
        model_reset();
        vecs[0] = '{1'b1, 4'b0001, 24'h041041, 4'b0001, 4'b0000};
        vecs[1] = '{1'b1, 4'b1100, 24'h041041, 4'b0100, 4'b0000};
        vecs[2] = '{1'b0, 4'b1111, 24'h041041, 4'b0000, 4'b0000};
        vecs[3] = '{1'b1, 4'b1000, 24'h041041, 4'b1000, 4'b0000};
        vecs[4] = '{1'b1, 4'b0110, 24'h041041, 4'b0010, 4'b0000};
        vecs[5] = '{1'b1, 4'b0100, 24'h040041, 4'b0100, 4'b0100};
        vecs[6] = '{1'b1, 4'b0000, 24'h041041, 4'b0000, 4'b0000};
        vecs[7] = '{1'b1, 4'b1010, 24'h041001, 4'b0010, 4'b0010};
        vecs[8] = '{1'b1, 4'b1111, 24'h000000, 4'b0001, 4'b0001};
        repeat (2) @(posedge clock);

        // Arbitration from the reset state: released briefly between clock edges.
        foreach (vecs[v]) begin
            @(negedge clock);
            cfg_enable = vecs[v].en;
            req_valid  = vecs[v].valid;
            req_op_id  = vecs[v].ids;
            #1;
            check("tbl_ready_in_reset", 32'(req_ready), 0);
            reset = 1'b0;
            #1;
            check($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            check($sformatf("tbl%0d_err", v), 32'(req_err), 32'(vecs[v].exp_err));
            reset = 1'b1;
        end
        @(posedge clock);
        #1;

        // Single write from requester 0.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b0001; req_addr = 32'h12; req_wr_data = 32'hA5;
        req_op_id = 24'h05; req_wr_rd_op = 4'b0001; ready_out = 1'b1;
        cycle();
        check("wr_grant", 32'(obs_ready), 32'h1);
        req_valid = '0;
        cycle();
        check("wr_valid_in", 32'(obs_vin), 1);
        check("wr_addr_in", 32'(obs_addr), 32'h12);
        check("wr_data_in", 32'(obs_wd), 32'hA5);
        check("wr_op_in_id", 32'(obs_id), 32'h05);

        // Fairness with all requesters pending.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b1111; req_op_id = 24'h041041; ready_out = 1'b1;
        repeat (10) begin
            cycle();
            if (obs_ready != 0) begin
                g_ids.push_back(idx_of(obs_ready));
                g_cyc.push_back(cyc);
            end
        end
        check("rr_count", 32'(g_ids.size()), 5);
        for (int j = 0; j < 5 && j < g_ids.size(); j++) begin
            check($sformatf("rr_order%0d", j), 32'(g_ids[j]), 32'(j % 4));
            if (j > 0) check($sformatf("rr_gap%0d", j), 32'(g_cyc[j] - g_cyc[j-1]), 2);
        end

        // Backpressure holds the issued op.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b0001; req_op_id = 24'h041041;
        req_addr = 32'h77; ready_out = 1'b0;
        cycle();
        req_valid = 4'b1111;
        repeat (5) begin
            req_addr = $urandom;
            cycle();
            check("bp_valid_in", 32'(obs_vin), 1);
            check("bp_addr_in", 32'(obs_addr), 32'h77);
            check("bp_no_ready", 32'(obs_ready), 0);
        end
        req_valid = '0; ready_out = 1'b1;
        cycle();
        cycle();

        // Outstanding limit on requester 1, then a completion frees a slot.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b0010; req_op_id = 24'h0001C0; ready_out = 1'b1;
        n_gr = 0;
        repeat (8) begin
            cycle();
            if (obs_ready[1]) n_gr++;
        end
        check("lim_grants", 32'(n_gr), 4);
        n_gr = 0;
        repeat (3) begin
            cycle();
            if (obs_ready != 0) n_gr++;
        end
        check("lim_blocked", 32'(n_gr), 0);
        done_op_id = 8'h47; rd_data_out = 8'h3C;
        cycle();
        done_op_id = '0; rd_data_out = '0;
        cycle();
        check("lim_rsp_valid", 32'(obs_rsp_v), 32'h2);
        check("lim_rsp_op_id", 32'(obs_rsp_id), 32'h07);
        check("lim_rsp_rd_data", 32'(obs_rsp_d), 32'h3C);
        check("lim_regrant", 32'(obs_ready), 32'h2);
        req_valid = '0;
        cycle();

        // Illegal op id.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b0100; req_op_id = '0; ready_out = 1'b1;
        cycle();
        check("ill_ready", 32'(obs_ready), 32'h4);
        check("ill_err", 32'(obs_err), 32'h4);
        check("ill_no_valid", 32'(obs_vin), 0);
        req_valid = '0;
        cycle();
        check("ill_no_valid_after", 32'(obs_vin), 0);

        // cfg_enable dropping mid-issue lets the op finish but blocks new grants.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b0001; req_op_id = 24'h041041; ready_out = 1'b0;
        cycle();
        cfg_enable = 1'b0;
        cycle();
        ready_out = 1'b1;
        cycle();
        check("dis_finish", 32'(obs_vin), 1);
        cycle();
        check("dis_no_grant", 32'(obs_ready), 0);
        check("dis_idle", 32'(obs_vin), 0);

        // Reset during issue drops valid_in at once and discards the op.
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b0001; req_op_id = 24'h041041; ready_out = 1'b0;
        cycle();
        cycle();
        check("mid_issue_valid", 32'(obs_vin), 1);
        reset = 1'b1;
        #1;
        check("rst_async_valid_in", 32'(valid_in), 0);
        do_reset();
        cfg_enable = 1'b1; req_valid = 4'b1111; ready_out = 1'b1;
        cycle();
        check("post_rst_grant", 32'(obs_ready), 32'h1);
        repeat (4) cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cfg_enable   = ($urandom_range(0, 9) != 0);
            req_valid    = 4'($urandom);
            req_wr_rd_op = 4'($urandom);
            req_addr     = $urandom;
            req_wr_data  = $urandom;
            req_op_id    = 24'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                lane = $urandom_range(0, 3);
                req_op_id[6*lane +: 6] = 6'd0;
            end
            ready_out   = ($urandom_range(0, 2) != 0);
            done_op_id  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rd_data_out = 8'($urandom);
            cycle();
            check("ready_onehot", 32'($onehot0(obs_ready)), 1);
            check("rsp_onehot", 32'($onehot0(obs_rsp_v)), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
